// File: rtl/robertson_pkg.sv
// Shared types and constants for the Robertson multiplier scheduler.
package robertson_pkg;

  localparam int ROB_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    WAIT,
    READ_LO,
    ABORT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past ptr and wraps,
// so the last granted requester ends up with the lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int IW = $clog2(N_REQ);

  always_comb begin
    int c;
    logic [IW-1:0] ci;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    ci  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      c  = (int'(ptr) + i) % N_REQ;
      ci = IW'(c);
      if (!any && req[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/robertson_sched.sv
// Round-robin scheduler sharing one Robertson 8x8 multiplier core between
// N_REQ requesters; loads M/Q, collects {A,Q} and guards with a watchdog.
module robertson_sched
  import robertson_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = ROB_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_m,
  input  logic [N_REQ*WIDTH-1:0]     req_q,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]         rsp_prod,
  output logic                       rsp_err,
  input  logic                       rsp_ready,
  output logic                       mul_rst_n,
  output logic                       mul_enable,
  output logic [WIDTH-1:0]           mul_inbus,
  input  logic                       mul_done,
  input  logic [WIDTH-1:0]           mul_outbus,
  output logic                       busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT) + 1;

  sched_state_t       state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      id_q, id_d;
  logic [WIDTH-1:0]   m_q, m_d, q_q, q_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;
  logic [WW-1:0]      wdog_q, wdog_d;
  logic               rst_hold_q, rst_hold_d;

  logic [N_REQ-1:0]   gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [WIDTH-1:0]   sel_m, sel_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    sel_m = '0;
    sel_q = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_m = req_m[i*WIDTH +: WIDTH];
        sel_q = req_q[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    m_d        = m_q;
    q_d        = q_q;
    prod_d     = prod_q;
    err_d      = err_q;
    wdog_d     = wdog_q;
    rst_hold_d = 1'b0;
    req_ready  = '0;
    mul_enable = 1'b0;
    mul_inbus  = '0;
    case (state_q)
      IDLE: begin
        if (gnt_any && !rst) begin
          req_ready = gnt;
          m_d       = sel_m;
          q_d       = sel_q;
          id_d      = gnt_idx;
          ptr_d     = gnt_idx;
          err_d     = 1'b0;
          state_d   = LOAD_M;
        end
      end
      LOAD_M: begin
        mul_enable = 1'b1;
        mul_inbus  = m_q;
        state_d    = LOAD_Q;
      end
      LOAD_Q: begin
        mul_inbus = q_q;
        wdog_d    = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // done takes precedence over an expiring watchdog
        if (mul_done) begin
          prod_d[2*WIDTH-1:WIDTH] = mul_outbus;
          state_d = READ_LO;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          state_d = ABORT;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      READ_LO: begin
        prod_d[WIDTH-1:0] = mul_outbus;
        state_d = RESP;
      end
      ABORT: begin
        prod_d  = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(N_REQ - 1);
      id_q       <= '0;
      m_q        <= '0;
      q_q        <= '0;
      prod_q     <= '0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      m_q        <= m_d;
      q_q        <= q_d;
      prod_q     <= prod_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
      rst_hold_q <= rst_hold_d;
    end
  end

  // core stays in reset one extra cycle after rst, and for the abort cycle
  assign mul_rst_n = !(rst || rst_hold_q || (state_q == ABORT));
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_prod  = prod_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_robertson_sched.sv
// Directed bench for robertson_sched with a behavioural multiplier core and
// a response scoreboard filled at grant time.
module tb_robertson_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_m, req_q;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [2*W-1:0]   rsp_prod;
  logic             rsp_err, rsp_ready;
  logic             mul_rst_n, mul_enable, mul_done, busy;
  logic [W-1:0]     mul_inbus, mul_outbus;

  robertson_sched #(.N_REQ(N), .WIDTH(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_m(req_m), .req_q(req_q),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_prod(rsp_prod), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .mul_rst_n(mul_rst_n), .mul_enable(mul_enable), .mul_inbus(mul_inbus),
    .mul_done(mul_done), .mul_outbus(mul_outbus), .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural core: M on enable, Q next cycle, done after model_delay WAIT cycles
  logic [W-1:0]       mcap = '0, qcap = '0;
  logic [1:0]         ph = 2'd0;
  int                 cnt = 0;
  int                 model_delay = 0;
  logic               model_hang = 1'b0;
  logic signed [15:0] mprod;
  assign mprod = $signed(mcap) * $signed(qcap);

  always @(posedge clk) begin
    if (!mul_rst_n) ph <= 2'd0;
    else case (ph)
      2'd0: if (mul_enable) begin mcap <= mul_inbus; ph <= 2'd1; end
      2'd1: begin qcap <= mul_inbus; cnt <= model_delay; ph <= 2'd2; end
      2'd2: if (!model_hang) begin
              if (cnt == 0) ph <= 2'd3;
              else cnt <= cnt - 1;
            end
      default: ph <= 2'd0;
    endcase
  end
  assign mul_done   = (ph == 2'd2) && !model_hang && (cnt == 0);
  assign mul_outbus = (ph == 2'd2) ? mprod[15:8] : (ph == 2'd3) ? mprod[7:0] : 8'h00;

  int cyc = 0;
  int rstn_low = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (mul_rst_n === 1'b0) rstn_low++;

  typedef struct {
    int          id;
    logic [15:0] prod;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int          vecs = 0;
  int          errs = 0;
  int          g_cyc = 0;
  bit          keep_valid = 1'b0;
  logic [15:0] last_prod;
  logic [7:0]  op_m [N];
  logic [7:0]  op_q [N];
  int          exp_order [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] eprod(input logic [7:0] m, input logic [7:0] q);
    logic signed [15:0] p;
    p = $signed(m) * $signed(q);
    return p;
  endfunction

  task automatic set_op(input int id, input logic [7:0] m, input logic [7:0] q);
    op_m[id] = m;
    op_q[id] = q;
    req_m[id*W +: W] = m;
    req_q[id*W +: W] = q;
  endtask

  task automatic wait_grant(output int gid, input bit exp_err);
    int n;
    exp_t e;
    n = 0;
    gid = -1;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_seen", {31'b0, req_ready != '0}, 1);
    chk("ready_onehot", $countones(req_ready), 1);
    for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
    g_cyc = cyc;
    if (gid >= 0) begin
      e.id   = gid;
      e.prod = exp_err ? 16'h0000 : eprod(op_m[gid], op_q[gid]);
      e.err  = exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep_valid && gid >= 0) req_valid[gid] = 1'b0;
  endtask

  task automatic collect(input int exp_lat);
    int n;
    exp_t e;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", rsp_valid, 1);
    if (exp_lat >= 0) chk("latency", cyc - g_cyc, exp_lat);
    chk("sb_nonempty", {31'b0, sb.size() > 0}, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_prod", rsp_prod, e.prod);
      chk("rsp_err", rsp_err, e.err);
    end
    last_prod = rsp_prod;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int id, input logic [7:0] m, input logic [7:0] q,
                        input int d, input bit hang, input int exp_lat);
    int g;
    model_delay = d;
    model_hang  = hang;
    set_op(id, m, q);
    req_valid[id] = 1'b1;
    wait_grant(g, hang);
    chk("grant_id", g, id);
    collect(exp_lat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int g;
    rst = 1'b1;
    req_valid = '1;
    req_m = '0;
    req_q = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_rst_n", mul_rst_n, 0);
    chk("rst_mul_enable", mul_enable, 0);
    chk("rst_mul_inbus", mul_inbus, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_prod", rsp_prod, 0);
    chk("rst_rsp_err", rsp_err, 0);
    req_valid = '0;
    rst = 1'b0;
    #1;
    chk("rstn_hold", mul_rst_n, 0);
    @(negedge clk);
    chk("rstn_release", mul_rst_n, 1);

    // single op and signed corners
    run_op(0, 8'd5, 8'hFD, 8, 1'b0, 13);
    chk("t1_prod", last_prod, 16'hFFF1);
    run_op(1, 8'h80, 8'h80, 0, 1'b0, 5);
    chk("t2_prod_a", last_prod, 16'h4000);
    run_op(2, 8'd127, 8'h80, 3, 1'b0, 8);
    chk("t2_prod_b", last_prod, 16'hC080);

    // round-robin with all requesters continuously valid
    do_reset();
    @(negedge clk);
    set_op(0, 8'd3, 8'd7);
    set_op(1, 8'hF9, 8'd11);
    set_op(2, 8'd100, 8'hC4);
    set_op(3, 8'h81, 8'd2);
    keep_valid = 1'b1;
    req_valid = '1;
    model_hang = 1'b0;
    for (int i = 0; i < 10; i++) begin
      model_delay = i % 3;
      wait_grant(g, 1'b0);
      chk("rr_order", g, exp_order[i]);
      if (i == 7) req_valid = 4'b0101;
      collect(5 + (i % 3));
    end
    keep_valid = 1'b0;
    req_valid = '0;

    // watchdog abort
    begin
      int base;
      base = rstn_low;
      run_op(3, 8'h11, 8'h22, 0, 1'b1, 68);
      chk("wd_rstn_low_cycles", rstn_low - base, 1);
      model_hang = 1'b0;
    end

    // backpressure: response held while another requester waits
    rsp_ready = 1'b0;
    model_delay = 2;
    set_op(0, 8'hE7, 8'd9);
    set_op(1, 8'd12, 8'd12);
    req_valid = 4'b0011;
    wait_grant(g, 1'b0);
    chk("bp_grant", g, 0);
    begin
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, sb[0].id);
      chk("bp_prod", rsp_prod, sb[0].prod);
      chk("bp_no_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    collect(-1);
    wait_grant(g, 1'b0);
    chk("bp_next_grant", g, 1);
    collect(-1);

    // reset in the middle of WAIT drops the operation
    set_op(2, 8'h55, 8'h66);
    model_hang = 1'b1;
    req_valid[2] = 1'b1;
    wait_grant(g, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_mul_enable", mul_enable, 0);
    chk("mid_mul_inbus", mul_inbus, 0);
    chk("mid_rsp_id", rsp_id, 0);
    chk("mid_rsp_prod", rsp_prod, 0);
    chk("mid_rsp_err", rsp_err, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_mul_rst_n", mul_rst_n, 0);
    rst = 1'b0;
    void'(sb.pop_back());
    model_hang = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 0);
    end
    run_op(2, 8'hF0, 8'h0F, 1, 1'b0, 6);
    chk("post_rst_prod", last_prod, 16'hFF10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
